// File: rtl/adder_tree_sched_if.sv
// Handshake bundle for adder_tree_sched: vector input channel and result output channel.
interface adder_tree_sched_if #(
    parameter int NUM_ELEMENTS = 10,
    parameter int BIT_LEN      = 16
);
    logic                            in_valid;
    logic                            in_ready;
    logic [NUM_ELEMENTS*BIT_LEN-1:0] in_terms;
    logic                            out_valid;
    logic                            out_ready;
    logic [BIT_LEN-1:0]              out_sum;
    logic                            out_ovf;

    // Producer/consumer side driving the block.
    modport master (
        output in_valid, in_terms, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    // The summing block itself.
    modport slave (
        input  in_valid, in_terms, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/adder_tree_sched.sv
// Time-multiplexed vector summer: one LANES-wide adder tree is reused over
// CHUNKS cycles, folding each chunk into a wide accumulator.

// Pure combinational binary reduction tree; unused leaves are tied to zero.
module adder_tree_2_to_1 #(
    parameter int NUM_ELEMENTS = 4,
    parameter int BIT_LEN      = 16
) (
    input  logic [NUM_ELEMENTS*BIT_LEN-1:0] i_terms,
    output logic [BIT_LEN-1:0]              o_sum
);
    localparam int DEPTH  = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 0;
    localparam int LEAVES = 1 << DEPTH;

    genvar lv, k;
    generate
        for (lv = 0; lv <= DEPTH; lv++) begin : g_lvl
            logic [BIT_LEN-1:0] w_node [LEAVES >> lv];
            for (k = 0; k < (LEAVES >> lv); k++) begin : g_node
                if (lv == 0) begin : g_leaf
                    if (k < NUM_ELEMENTS) begin : g_in
                        assign w_node[k] = i_terms[k*BIT_LEN +: BIT_LEN];
                    end else begin : g_zero
                        assign w_node[k] = '0;
                    end
                end else begin : g_add
                    assign w_node[k] = g_lvl[lv-1].w_node[2*k] + g_lvl[lv-1].w_node[2*k+1];
                end
            end
        end
    endgenerate

    assign o_sum = g_lvl[DEPTH].w_node[0];
endmodule

module adder_tree_sched #(
    parameter int NUM_ELEMENTS = 10,
    parameter int BIT_LEN      = 16,
    parameter int LANES        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    adder_tree_sched_if.slave   bus,
    output logic                busy
);
    localparam int CHUNKS = (NUM_ELEMENTS + LANES - 1) / LANES;
    localparam int TREE_W = BIT_LEN + $clog2(LANES);
    localparam int ACC_W  = BIT_LEN + $clog2(NUM_ELEMENTS) + 1;
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int PAD_W  = CHUNKS * LANES * BIT_LEN;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                      r_state;
    logic [IDX_W-1:0]                r_idx;
    logic [ACC_W-1:0]                r_acc;
    logic [NUM_ELEMENTS*BIT_LEN-1:0] r_terms;

    logic [PAD_W-1:0]         w_padded;
    logic [LANES*BIT_LEN-1:0] w_slice;
    logic [LANES*TREE_W-1:0]  w_tree_in;
    logic [TREE_W-1:0]        w_tree_sum;

    // Zero-extending the captured vector to a whole number of chunks makes
    // the lanes past the last element read as zero in the final chunk.
    assign w_padded = PAD_W'(r_terms);
    assign w_slice  = w_padded[32'(r_idx) * LANES * BIT_LEN +: LANES * BIT_LEN];

    genvar l;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            assign w_tree_in[l*TREE_W +: TREE_W] = TREE_W'(w_slice[l*BIT_LEN +: BIT_LEN]);
        end
    endgenerate

    adder_tree_2_to_1 #(
        .NUM_ELEMENTS (LANES),
        .BIT_LEN      (TREE_W)
    ) u_tree (
        .i_terms (w_tree_in),
        .o_sum   (w_tree_sum)
    );

    // FSM: capture in IDLE, accumulate one chunk per cycle in RUN, hold result in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_acc   <= '0;
            r_terms <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_terms <= bus.in_terms;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= r_acc + ACC_W'(w_tree_sum);
                    if (r_idx == LAST_IDX) begin
                        // index parks at 0 so the slice never points past the vector
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_sum   = bus.out_valid ? r_acc[BIT_LEN-1:0] : '0;
    assign bus.out_ovf   = bus.out_valid ? (|r_acc[ACC_W-1:BIT_LEN]) : 1'b0;
    assign busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_adder_tree_sched.sv
// Bench for adder_tree_sched: table vectors, hand-built corner sequences and
// randomized vectors against a plain-arithmetic sum model.
module tb_adder_tree_sched;
    localparam int NE = 10;
    localparam int BW = 16;
    localparam int LN = 4;
    localparam int CH = 3;
    localparam int TW = NE * BW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy, busy2;
    int   checks = 0;
    int   errors = 0;

    adder_tree_sched_if #(.NUM_ELEMENTS(NE), .BIT_LEN(BW)) bus  ();
    adder_tree_sched_if #(.NUM_ELEMENTS(4),  .BIT_LEN(16)) bus2 ();

    adder_tree_sched #(.NUM_ELEMENTS(NE), .BIT_LEN(BW), .LANES(LN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    adder_tree_sched #(.NUM_ELEMENTS(4), .BIT_LEN(16), .LANES(4)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2),
        .busy  (busy2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] terms;
        logic [15:0]   sum;
        logic          ovf;
        int            stall;
        bit            noise;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] fill(input logic [15:0] v);
        logic [TW-1:0] t;
        for (int i = 0; i < NE; i++) t[i*BW +: BW] = v;
        return t;
    endfunction

    function automatic logic [TW-1:0] rnd_terms(input int mode);
        logic [TW-1:0] t;
        logic [15:0]   v;
        for (int i = 0; i < NE; i++) begin
            v = 16'($urandom);
            if (mode == 1) v = v & 16'h0FFF;
            if (mode == 2) v = v & 16'h1FFF;
            t[i*BW +: BW] = v;
        end
        return t;
    endfunction

    // Reference: the true integer sum of all elements.
    function automatic longint model(input logic [TW-1:0] t);
        longint tot = 0;
        for (int i = 0; i < NE; i++) tot += longint'(t[i*BW +: BW]);
        return tot;
    endfunction

    task automatic run_vec(input string nm, input logic [TW-1:0] terms, input logic [15:0] es,
                           input logic eo, input int stall, input bit noise);
        int n;
        int lat;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_terms  = terms;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_terms = rnd_terms(0);
        chk({nm, " busy"}, 64'(busy), 64'd1);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(CH));
        chk({nm, " sum"}, 64'(bus.out_sum), 64'(es));
        chk({nm, " ovf"}, 64'(bus.out_ovf), 64'(eo));
        for (int s = 0; s < stall; s++) begin
            if (noise) begin
                bus.in_valid = 1'b1;
                bus.in_terms = rnd_terms(0);
            end
            @(negedge clk);
            chk({nm, " stall valid"}, 64'(bus.out_valid), 64'd1);
            chk({nm, " stall sum"}, 64'(bus.out_sum), 64'(es));
            chk({nm, " stall ovf"}, 64'(bus.out_ovf), 64'(eo));
            chk({nm, " stall in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({nm, " valid drop"}, 64'(bus.out_valid), 64'd0);
        chk({nm, " idle ready"}, 64'(bus.in_ready), 64'd1);
        chk({nm, " idle busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TW-1:0] t;
        longint        tot;

        // Reset asserted with a pending vector: reset must win.
        bus.in_valid  = 1'b1;
        bus.in_terms  = fill(16'h1234);
        bus.out_ready = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.in_terms  = '0;
        bus2.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst out_sum", 64'(bus.out_sum), 64'd0);
        chk("rst out_ovf", 64'(bus.out_ovf), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        t = '0;
        for (int i = 0; i < NE; i++) t[i*BW +: BW] = 16'(i + 1);
        tbl[0] = '{fill(16'h0FFF), 16'h9FF6, 1'b0, 0, 1'b0};
        tbl[1] = '{fill(16'hFFFF), 16'hFFF6, 1'b1, 0, 1'b0};
        tbl[2] = '{t,              16'h0037, 1'b0, 5, 1'b1};
        tbl[3] = '{fill(16'h0000), 16'h0000, 1'b0, 1, 1'b0};
        t = '0; t[9*BW +: BW] = 16'hFFFF;
        tbl[4] = '{t,              16'hFFFF, 1'b0, 0, 1'b0};
        t = '0; t[8*BW +: BW] = 16'h8000; t[9*BW +: BW] = 16'h8000;
        tbl[5] = '{t,              16'h0000, 1'b1, 2, 1'b1};
        t = '0; t[0] = 1'b1; t[1*BW +: BW] = 16'hFFFE;
        tbl[6] = '{t,              16'hFFFF, 1'b0, 0, 1'b0};

        for (int v = 0; v < 7; v++)
            run_vec($sformatf("tbl%0d", v), tbl[v].terms, tbl[v].sum, tbl[v].ovf,
                    tbl[v].stall, tbl[v].noise);

        // Reset during the second RUN cycle discards the vector.
        bus.in_terms  = fill(16'hFFFF);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst out_sum", 64'(bus.out_sum), 64'd0);
        chk("midrst out_ovf", 64'(bus.out_ovf), 64'd0);
        chk("midrst busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        run_vec("post_rst", fill(16'h0001), 16'h000A, 1'b0, 0, 1'b0);

        // Single-chunk configuration: one RUN cycle.
        bus2.in_terms = {4{16'h4000}};
        bus2.in_valid = 1'b1;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        chk("c1 early valid", 64'(bus2.out_valid), 64'd0);
        @(negedge clk);
        chk("c1 valid", 64'(bus2.out_valid), 64'd1);
        chk("c1 sum", 64'(bus2.out_sum), 64'd0);
        chk("c1 ovf", 64'(bus2.out_ovf), 64'd1);
        @(negedge clk);
        chk("c1 valid drop", 64'(bus2.out_valid), 64'd0);

        for (int r = 0; r < 30; r++) begin
            t   = rnd_terms(int'($urandom_range(0, 2)));
            tot = model(t);
            run_vec($sformatf("rand%0d", r), t, tot[15:0], (tot >= 64'sd65536),
                    int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_tree_sched.md
ADDER_TREE_SCHED -- requirements
Module: adder_tree_sched

Interface
REQ-001 Parameter NUM_ELEMENTS, default 10: number of terms per input vector, SHALL be >= 1.
REQ-002 Parameter BIT_LEN, default 16: width of each term and of out_sum.
REQ-003 Parameter LANES, default 4: width of the shared adder tree, SHALL satisfy 1 <= LANES <= NUM_ELEMENTS.
REQ-004 Derived CHUNKS = ceil(NUM_ELEMENTS/LANES); derived ACC_W = BIT_LEN + clog2(NUM_ELEMENTS) + 1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 in_valid  input  1  in_terms holds a valid vector.
REQ-008 in_ready  output  1  block can accept a vector.
REQ-009 in_terms  input  NUM_ELEMENTS*BIT_LEN  unsigned terms; element i at bits [i*BIT_LEN +: BIT_LEN].
REQ-010 out_valid  output  1  out_sum/out_ovf hold a result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_sum  output  BIT_LEN  sum of all terms modulo 2^BIT_LEN.
REQ-013 out_ovf  output  1  true sum >= 2^BIT_LEN.
REQ-014 busy  output  1  high in RUN and DONE.

Function
REQ-015 Block SHALL contain exactly one adder_tree_2_to_1 instance, NUM_ELEMENTS=LANES, BIT_LEN=BIT_LEN+clog2(LANES), inputs zero-extended; no other multi-operand adder.
REQ-016 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-017 IDLE: in_ready=1; on in_valid&&in_ready, register in_terms, clear accumulator (ACC_W bits) and chunk index to 0, go to RUN.
REQ-018 RUN: each cycle, tree input = captured elements [idx*LANES +: LANES]; positions >= NUM_ELEMENTS SHALL be driven to zero; accumulator += tree output; idx++.
REQ-019 RUN -> DONE on the cycle that processes idx == CHUNKS-1; exactly CHUNKS RUN cycles per vector.
REQ-020 DONE: out_valid=1; out_sum = accumulator[BIT_LEN-1:0]; out_ovf = |accumulator[ACC_W-1:BIT_LEN].
REQ-021 DONE -> IDLE on out_valid&&out_ready; out_valid deasserts the following cycle.
REQ-022 While out_valid=1 and out_ready=0, out_sum and out_ovf SHALL remain stable.
REQ-023 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored and not alter state.
REQ-024 Latency: input handshake at edge T -> out_valid first high after edge T+CHUNKS.
REQ-025 Minimum issue interval CHUNKS+2 cycles (no overlap of vectors).
REQ-026 Captured terms SHALL not change between accept and result handshake, regardless of in_terms.
REQ-027 CHUNKS=1 SHALL be supported: one RUN cycle.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force state IDLE, idx=0, accumulator=0, captured terms=0.
REQ-029 Output values during/after reset: in_ready=1, out_valid=0, out_sum=0, out_ovf=0, busy=0.
REQ-030 Reset in RUN or DONE SHALL discard the vector in progress with no residue in the next result.
REQ-031 Reset SHALL have priority over any simultaneous handshake.

Verification
REQ-032 Defaults, all terms 0x0FFF, out_ready=1 -> out_sum=0x9FF6, out_ovf=0, out_valid high 3 cycles after accept edge.
REQ-033 All terms 0xFFFF -> true sum 0x9FFF6: out_sum=0xFFF6, out_ovf=1.
REQ-034 Terms i+1 (1..10) -> out_sum=0x0037, out_ovf=0; proves zero-padding of lanes 2,3 in chunk 2.
REQ-035 out_ready low 5 cycles in DONE while in_valid=1 with new terms -> out_valid/out_sum stable, in_ready=0; after out_ready=1, new vector accepted and summed correctly.
REQ-036 rst_n low one cycle during second RUN cycle -> reset outputs per REQ-029 next cycle; following vector of 0x0001 terms yields out_sum=0x000A.
REQ-037 NUM_ELEMENTS=4, LANES=4, terms 0x4000 -> out_sum=0x0000, out_ovf=1, out_valid one cycle after accept.
